// File: rtl/csr_fwd_track_if.sv
// Bus bundle for the CSR forwarding tracker: EX write, late fill, pipeline control,
// lookup channels and commit.
interface csr_fwd_track_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NRD    = 2,
  parameter int unsigned SRC_W  = 3
) ();
  logic                    stall_i;
  logic [DEPTH-1:0]        flush_mask_i;
  logic                    ex_we_i;
  logic [ADDR_W-1:0]       ex_addr_i;
  logic [XLEN-1:0]         ex_data_i;
  logic                    ex_ready_i;
  logic                    fill_we_i;
  logic [XLEN-1:0]         fill_data_i;
  logic [NRD*ADDR_W-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0]     rd_base_i;
  logic [NRD*XLEN-1:0]     rd_data_o;
  logic [NRD*SRC_W-1:0]    rd_src_o;
  logic [NRD-1:0]          rd_hazard_o;
  logic                    cm_valid_o;
  logic [ADDR_W-1:0]       cm_addr_o;
  logic [XLEN-1:0]         cm_data_o;
  logic                    cm_err_o;

  modport master (
    output stall_i, flush_mask_i, ex_we_i, ex_addr_i, ex_data_i, ex_ready_i,
           fill_we_i, fill_data_i, rd_addr_i, rd_base_i,
    input  rd_data_o, rd_src_o, rd_hazard_o, cm_valid_o, cm_addr_o, cm_data_o, cm_err_o
  );

  modport slave (
    input  stall_i, flush_mask_i, ex_we_i, ex_addr_i, ex_data_i, ex_ready_i,
           fill_we_i, fill_data_i, rd_addr_i, rd_base_i,
    output rd_data_o, rd_src_o, rd_hazard_o, cm_valid_o, cm_addr_o, cm_data_o, cm_err_o
  );
endinterface

// File: rtl/csr_fwd_track.sv
// In-flight CSR write tracker: shift pipeline of write records from EX to commit,
// with youngest-match forwarding, late data fill, per-stage flush and stall hold.
module csr_fwd_track #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned NRD        = 2,
  parameter int unsigned FILL_STAGE = 1,
  parameter int unsigned SRC_W      = 3
) (
  input logic             clk,
  input logic             rstn,
  csr_fwd_track_if.slave  bus
);

  typedef struct packed {
    logic              vld;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } rec_t;

  // Index 0 is stage 1 (youngest); index DEPTH-1 is the commit stage.
  rec_t stg_q [DEPTH];
  rec_t stg_d [DEPTH];
  rec_t filled[DEPTH];
  logic cm_err_q, cm_err_d;

  logic [NRD*XLEN-1:0]  rd_data_c;
  logic [NRD*SRC_W-1:0] rd_src_c;
  logic [NRD-1:0]       rd_hazard_c;

  // Next-state: fill, then shift or hold, then flush on the resulting positions.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      filled[k] = stg_q[k];
    end
    if (bus.fill_we_i && filled[FILL_STAGE-1].vld && !filled[FILL_STAGE-1].rdy) begin
      filled[FILL_STAGE-1].data = bus.fill_data_i;
      filled[FILL_STAGE-1].rdy  = 1'b1;
    end

    for (int k = 0; k < int'(DEPTH); k++) begin
      stg_d[k] = filled[k];
    end
    if (!bus.stall_i) begin
      stg_d[0].vld  = bus.ex_we_i;
      stg_d[0].rdy  = bus.ex_ready_i;
      stg_d[0].addr = bus.ex_addr_i;
      stg_d[0].data = bus.ex_data_i;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stg_d[k] = filled[k-1];
      end
    end

    for (int k = 0; k < int'(DEPTH); k++) begin
      if (bus.flush_mask_i[k]) begin
        stg_d[k].vld = 1'b0;
      end
    end

    cm_err_d = cm_err_q;
    if (stg_q[DEPTH-1].vld && !stg_q[DEPTH-1].rdy && !bus.stall_i) begin
      cm_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        stg_q[k] <= '0;
      end
      cm_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        stg_q[k] <= stg_d[k];
      end
      cm_err_q <= cm_err_d;
    end
  end

  // Lookup: scan oldest to youngest so the youngest match overrides; a not-ready
  // youngest match hides any older ready one.
  always_comb begin
    rd_data_c   = '0;
    rd_src_c    = '0;
    rd_hazard_c = '0;
    for (int j = 0; j < int'(NRD); j++) begin
      rd_data_c[j*XLEN +: XLEN] = bus.rd_base_i[j*XLEN +: XLEN];
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (stg_q[k].vld && (stg_q[k].addr == bus.rd_addr_i[j*ADDR_W +: ADDR_W])) begin
          rd_src_c[j*SRC_W +: SRC_W] = SRC_W'(k + 1);
          rd_hazard_c[j]             = !stg_q[k].rdy;
          rd_data_c[j*XLEN +: XLEN]  = stg_q[k].rdy ? stg_q[k].data
                                                    : bus.rd_base_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  assign bus.rd_data_o   = rd_data_c;
  assign bus.rd_src_o    = rd_src_c;
  assign bus.rd_hazard_o = rd_hazard_c;

  assign bus.cm_valid_o = stg_q[DEPTH-1].vld & stg_q[DEPTH-1].rdy & ~bus.stall_i;
  assign bus.cm_addr_o  = stg_q[DEPTH-1].vld ? stg_q[DEPTH-1].addr : '0;
  assign bus.cm_data_o  = stg_q[DEPTH-1].vld ? stg_q[DEPTH-1].data : '0;
  assign bus.cm_err_o   = cm_err_q;

endmodule

// File: tb/tb_csr_fwd_track.sv
// Directed bench for csr_fwd_track (DEPTH=3, NRD=2): forwarding, youngest-wins,
// flush, late fill, stall hold, commit error and asynchronous reset.
module tb_csr_fwd_track;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned NRD    = 2;
  localparam int unsigned SRC_W  = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  csr_fwd_track_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD), .SRC_W(SRC_W)) bus ();

  csr_fwd_track #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD),
                  .FILL_STAGE(1), .SRC_W(SRC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_wr(input logic [11:0] a, input logic [63:0] d, input logic rdy);
    bus.ex_we_i    = 1'b1;
    bus.ex_addr_i  = a;
    bus.ex_data_i  = d;
    bus.ex_ready_i = rdy;
  endtask

  task automatic lookup(input logic [11:0] a0, input logic [63:0] b0,
                        input logic [11:0] a1, input logic [63:0] b1);
    bus.rd_addr_i = {a1, a0};
    bus.rd_base_i = {b1, b0};
    #1;
  endtask

  task automatic chk_ch0(input string tag, input logic [63:0] d, input logic [2:0] s, input logic h);
    chk({tag, ".data0"}, bus.rd_data_o[63:0], d);
    chk({tag, ".src0"},  64'(bus.rd_src_o[2:0]), 64'(s));
    chk({tag, ".haz0"},  64'(bus.rd_hazard_o[0]), 64'(h));
  endtask

  initial begin
    bus.stall_i = 1'b0; bus.flush_mask_i = '0;
    bus.ex_we_i = 1'b0; bus.ex_addr_i = '0; bus.ex_data_i = '0; bus.ex_ready_i = 1'b0;
    bus.fill_we_i = 1'b0; bus.fill_data_i = '0;
    bus.rd_addr_i = '0; bus.rd_base_i = '0;

    // Reset state
    lookup(12'h300, 64'h1, 12'h301, 64'h2);
    chk_ch0("rst", 64'h1, 3'd0, 1'b0);
    chk("rst.data1", bus.rd_data_o[127:64], 64'h2);
    chk("rst.cm_valid", 64'(bus.cm_valid_o), 64'h0);
    chk("rst.cm_addr",  64'(bus.cm_addr_o), 64'h0);
    chk("rst.cm_data",  bus.cm_data_o, 64'h0);
    chk("rst.cm_err",   64'(bus.cm_err_o), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Forward from stage 1 through commit
    ex_wr(12'h300, 64'hA, 1'b1);
    tick();
    bus.ex_we_i = 1'b0;
    lookup(12'h300, 64'h1, 12'h301, 64'h2);
    chk_ch0("fwd.s1", 64'hA, 3'd1, 1'b0);
    chk("fwd.s1.data1", bus.rd_data_o[127:64], 64'h2);
    chk("fwd.s1.src1", 64'(bus.rd_src_o[5:3]), 64'h0);
    tick();
    chk_ch0("fwd.s2", 64'hA, 3'd2, 1'b0);
    tick();
    chk_ch0("fwd.s3", 64'hA, 3'd3, 1'b0);
    chk("fwd.cm_valid", 64'(bus.cm_valid_o), 64'h1);
    chk("fwd.cm_addr",  64'(bus.cm_addr_o), 64'h300);
    chk("fwd.cm_data",  bus.cm_data_o, 64'hA);
    tick();
    chk_ch0("fwd.gone", 64'h1, 3'd0, 1'b0);
    chk("fwd.gone.cm_valid", 64'(bus.cm_valid_o), 64'h0);

    // Youngest wins, then flush the post-shift stage 2 to expose the older record
    ex_wr(12'h341, 64'h10, 1'b1);
    tick();
    ex_wr(12'h341, 64'h20, 1'b1);
    tick();
    bus.ex_we_i = 1'b0;
    lookup(12'h341, 64'h1, 12'h341, 64'h2);
    chk_ch0("yw", 64'h20, 3'd1, 1'b0);
    chk("yw.data1", bus.rd_data_o[127:64], 64'h20);
    chk("yw.src1", 64'(bus.rd_src_o[5:3]), 64'h1);
    bus.flush_mask_i = 3'b010;
    tick();
    bus.flush_mask_i = 3'b000;
    chk_ch0("yw.flush", 64'h10, 3'd3, 1'b0);
    chk("yw.flush.cm_data", bus.cm_data_o, 64'h10);
    tick();
    chk_ch0("yw.drain", 64'h1, 3'd0, 1'b0);

    // Late fill while shifting: entry moves to stage 2 already ready
    ex_wr(12'h305, 64'hDEAD, 1'b0);
    tick();
    bus.ex_we_i = 1'b0;
    lookup(12'h305, 64'h1, 12'h300, 64'h2);
    chk_ch0("fill.pre", 64'h1, 3'd1, 1'b1);
    bus.fill_we_i = 1'b1; bus.fill_data_i = 64'h55;
    tick();
    bus.fill_we_i = 1'b0;
    chk_ch0("fill.post", 64'h55, 3'd2, 1'b0);
    tick();
    chk("fill.cm_valid", 64'(bus.cm_valid_o), 64'h1);
    chk("fill.cm_data",  bus.cm_data_o, 64'h55);
    tick();

    // Stall holds all stages and drops the EX write
    ex_wr(12'h310, 64'h1001, 1'b1); tick();
    ex_wr(12'h311, 64'h1002, 1'b1); tick();
    ex_wr(12'h312, 64'h1003, 1'b1); tick();
    ex_wr(12'h313, 64'h1004, 1'b1);
    bus.stall_i = 1'b1;
    lookup(12'h310, 64'h1, 12'h313, 64'h2);
    for (int i = 0; i < 3; i++) begin
      chk("stall.cm_valid", 64'(bus.cm_valid_o), 64'h0);
      chk_ch0("stall.hold", 64'h1001, 3'd3, 1'b0);
      chk("stall.drop.data1", bus.rd_data_o[127:64], 64'h2);
      chk("stall.drop.src1", 64'(bus.rd_src_o[5:3]), 64'h0);
      tick();
    end
    bus.stall_i = 1'b0;
    bus.ex_we_i = 1'b0;
    lookup(12'h312, 64'h1, 12'h310, 64'h2);
    #1;
    chk_ch0("stall.after", 64'h1003, 3'd1, 1'b0);
    chk("stall.after.cm_valid", 64'(bus.cm_valid_o), 64'h1);
    chk("stall.after.cm_data",  bus.cm_data_o, 64'h1001);
    tick(); tick(); tick();

    // Not-ready record reaches commit without fill: sticky error
    ex_wr(12'h320, 64'h0, 1'b0);
    tick();
    bus.ex_we_i = 1'b0;
    tick(); tick();
    chk("err.cm_valid", 64'(bus.cm_valid_o), 64'h0);
    chk("err.cm_addr",  64'(bus.cm_addr_o), 64'h320);
    chk("err.before",   64'(bus.cm_err_o), 64'h0);
    tick();
    chk("err.set",      64'(bus.cm_err_o), 64'h1);
    tick(); tick();
    chk("err.sticky",   64'(bus.cm_err_o), 64'h1);

    // Asynchronous reset between edges with three valid stages
    ex_wr(12'h330, 64'h7, 1'b1); tick();
    ex_wr(12'h331, 64'h8, 1'b1); tick();
    ex_wr(12'h332, 64'h9, 1'b1); tick();
    bus.ex_we_i = 1'b0;
    lookup(12'h330, 64'h1, 12'h332, 64'h2);
    chk_ch0("arst.pre", 64'h7, 3'd3, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_ch0("arst", 64'h1, 3'd0, 1'b0);
    chk("arst.data1",   bus.rd_data_o[127:64], 64'h2);
    chk("arst.src1",    64'(bus.rd_src_o[5:3]), 64'h0);
    chk("arst.cm_valid",64'(bus.cm_valid_o), 64'h0);
    chk("arst.cm_addr", 64'(bus.cm_addr_o), 64'h0);
    chk("arst.cm_err",  64'(bus.cm_err_o), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk_ch0("arst.post", 64'h1, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
